// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants, fetch state encoding and queue entry type
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_QDEPTH   = 2;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - registered instruction FIFO with flush; head is read combinationally
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_QDEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output fetch_entry_t     head_entry
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  // a pop frees the slot in the same cycle, so push-on-full with pop is accepted
  assign do_push    = push && ((count != FULL) || do_pop);
  assign head_entry = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with redirect and decoder queue
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = DEFAULT_QDEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int               CNT_W            = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] QFULL            = CNT_W'(QDEPTH);
  localparam logic [31:0]      RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_pc_nxt;
  logic [31:0]      pending_pc;
  logic [31:0]      pending_pc_nxt;
  logic             req_c;
  logic             q_push;
  logic             q_pop;
  logic             q_flush;
  logic             q_valid;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_in;
  fetch_entry_t     q_head;

  assign q_in = '{word: imem_rdata, pc: pending_pc};

  fetch_queue #(
    .DEPTH (QDEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_entry (q_in),
    .pop        (q_pop),
    .flush      (q_flush),
    .count      (q_count),
    .head_valid (q_valid),
    .head_entry (q_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_REQ;
      fetch_pc   <= RESET_PC_ALIGNED;
      pending_pc <= '0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      pending_pc <= pending_pc_nxt;
    end
  end

  // redirect overrides everything; only the outstanding-response bookkeeping survives it
  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    pending_pc_nxt = pending_pc;
    req_c          = 1'b0;
    q_push         = 1'b0;
    q_flush        = 1'b0;
    if (redirect) begin
      q_flush      = 1'b1;
      fetch_pc_nxt = redirect_pc & ~32'h3;
      if (state != ST_REQ) begin
        state_nxt = imem_rvalid ? ST_REQ : ST_DROP;
      end
    end else begin
      case (state)
        ST_REQ: begin
          req_c = (q_count < QFULL);
          if (req_c && imem_gnt) begin
            fetch_pc_nxt   = pc_next(fetch_pc);
            pending_pc_nxt = fetch_pc;
            state_nxt      = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            q_push    = 1'b1;
            state_nxt = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rvalid) begin
            state_nxt = ST_REQ;
          end
        end
        default: state_nxt = ST_REQ;
      endcase
    end
  end

  assign q_pop      = inst_valid && inst_ready && !redirect;
  assign imem_req   = req_c && !reset;
  assign imem_addr  = fetch_pc;
  assign inst_valid = q_valid && !reset;
  assign inst       = inst_valid ? q_head.word : NOP_INST;
  assign inst_pc    = inst_valid ? q_head.pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit against a queue-level model
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam int          QD     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .QDEPTH   (QD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_ready  (inst_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          outstanding;
  bit          resp_busy;
  bit          resp_live;
  int          resp_cnt;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic [31:0] exp_pc;
  int          gcount;
  bit          force_data_en;
  logic [31:0] force_data;
  bit          mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock of stimulus; the model advances at the rising edge
  task automatic cyc(input bit rst, input bit g, input bit rdy, input bit rd,
                     input logic [31:0] rpc, input int lat, input bit stray);
    bit real_rv;
    bit exp_req;
    bit hs;
    exp_req = 1'b0;
    @(negedge clk);
    real_rv     = resp_busy && (resp_cnt == 1);
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
    imem_gnt    = g && !resp_busy;
    imem_rvalid = real_rv || (stray && !resp_busy);
    imem_rdata  = real_rv ? resp_data : $urandom;
    #1;
    if (rst) begin
      chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      chk("rst_inst", inst, 32'h0000_0013);
      chk("rst_inst_pc", inst_pc, 32'h0);
    end else begin
      exp_req = !outstanding && (exp_q.size() < QD) && !rd;
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, exp_pc);
    end
    hs = !rst && exp_req && imem_gnt;
    if (hs && gcount == 0) chk("first_fetch_addr", imem_addr, 32'hFFFF_FFFC);
    if (hs && gcount == 1) chk("second_fetch_addr", imem_addr, 32'h0000_0000);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      outstanding = 1'b0;
      resp_live   = 1'b0;
      exp_pc      = RST_PC;
      gcount      = 0;
    end else if (rd) begin
      exp_q.delete();
      exp_pc = rpc & ~32'h3;
      gcount = 2;
      if (real_rv) outstanding = 1'b0;
      resp_live = 1'b0;
    end else if (real_rv && outstanding) begin
      if (resp_live) exp_q.push_back('{word: resp_data, pc: resp_addr});
      outstanding = 1'b0;
    end
    if (real_rv) resp_busy = 1'b0;
    else if (resp_busy) resp_cnt--;
    if (hs) begin
      resp_busy   = 1'b1;
      resp_live   = 1'b1;
      resp_cnt    = (lat == 0) ? int'($urandom_range(1, 3)) : lat;
      resp_addr   = exp_pc;
      resp_data   = force_data_en ? force_data : $urandom;
      outstanding = 1'b1;
      exp_pc      = exp_pc + 32'd4;
      gcount++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !reset) begin
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() == 0) begin
          chk("idle_inst", inst, 32'h0000_0013);
          chk("idle_inst_pc", inst_pc, 32'h0);
        end else begin
          chk("inst", inst, exp_q[0].word);
          chk("inst_pc", inst_pc, exp_q[0].pc);
          if (inst_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    inst_ready    = 1'b0;
    outstanding   = 1'b0;
    resp_busy     = 1'b0;
    resp_live     = 1'b0;
    resp_cnt      = 0;
    resp_data     = 32'h0;
    resp_addr     = 32'h0;
    exp_pc        = RST_PC;
    gcount        = 0;
    force_data_en = 1'b0;
    force_data    = 32'h0;
    mon_en        = 1'b1;

    repeat (3) cyc(1, 0, 0, 0, 32'h0, 1, 0);

    // streaming: grant always, one-cycle memory, decoder always ready
    repeat (20) cyc(0, 1, 1, 0, 32'h0, 1, 0);

    // decoder stalls until the queue fills, then drains
    repeat (8) cyc(0, 1, 0, 0, 32'h0, 1, 0);
    repeat (10) cyc(0, 1, 1, 0, 32'h0, 1, 0);

    // grant withheld for three cycles
    repeat (3) cyc(0, 0, 1, 0, 32'h0, 1, 0);
    repeat (4) cyc(0, 1, 1, 0, 32'h0, 1, 0);

    // redirect while waiting; late response must be dropped
    repeat (6) cyc(0, 0, 1, 0, 32'h0, 1, 0);
    force_data_en = 1'b1;
    force_data    = 32'hDEAD_BEEF;
    cyc(0, 1, 1, 0, 32'h0, 2, 0);
    force_data_en = 1'b0;
    cyc(0, 0, 1, 1, 32'h0000_0103, 1, 0);
    cyc(0, 0, 1, 0, 32'h0, 1, 0);
    #1;
    chk("drop_next_addr", imem_addr, 32'h0000_0100);
    chk("drop_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("drop_inst", inst, 32'h0000_0013);
    chk("drop_imem_req", {31'b0, imem_req}, 32'h1);
    repeat (6) cyc(0, 1, 1, 0, 32'h0, 1, 0);

    // reset during an outstanding fetch; its response arrives after release
    repeat (6) cyc(0, 0, 1, 0, 32'h0, 1, 0);
    cyc(0, 1, 1, 0, 32'h0, 3, 0);
    repeat (2) cyc(1, 0, 1, 0, 32'h0, 1, 0);
    cyc(0, 0, 1, 0, 32'h0, 1, 0);
    #1;
    chk("stray_inst_valid", {31'b0, inst_valid}, 32'h0);
    chk("stray_next_addr", imem_addr, RST_PC);
    repeat (10) cyc(0, 1, 1, 0, 32'h0, 1, 0);

    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 19) == 0,
          $urandom,
          0,
          $urandom_range(0, 9) == 0);
    end

    repeat (10) cyc(0, 0, 1, 0, 32'h0, 1, 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
